// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding-select codes,
// the scoreboard slot record and the register-match helper.
package hazard_pkg;

  localparam int ADDR_W_DEF = 5;

  // D-stage operand select
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_W  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_E  = 2'd3;

  // E-stage ALU operand select
  localparam logic [1:0] FWDE_PIPE = 2'd0;
  localparam logic [1:0] FWDE_W    = 2'd1;
  localparam logic [1:0] FWDE_M    = 2'd2;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [1:0]            tnew;
    logic [ADDR_W_DEF-1:0] rs;
    logic [ADDR_W_DEF-1:0] rt;
  } slot_t;

  // $0 is hardwired, so a write to it never produces a usable result.
  function automatic logic slot_match(input slot_t s, input logic [ADDR_W_DEF-1:0] src);
    return s.we && (s.addr == src) && (src != '0);
  endfunction

endpackage

// File: rtl/hazard_slot.sv
// One scoreboard stage register: async clear, bubble insertion and an
// optional saturating decrement of the remaining-latency field.
module hazard_slot
  import hazard_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  bubble,
  input  logic  dec,
  input  slot_t d,
  output slot_t q
);

  slot_t q_nxt;

  always_comb begin
    q_nxt = d;
    if (dec && (d.tnew != 2'd0)) begin
      q_nxt.tnew = d.tnew - 2'd1;
    end
    if (bubble) begin
      q_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= q_nxt;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage MIPS hazard controller: tracks in-flight writers in E/M/W slots and
// derives the D-stage stall plus the D/E/M forwarding selects combinationally.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs_D,
  input  logic [ADDR_W-1:0] rt_D,
  input  logic              rs_use_D,
  input  logic              rt_use_D,
  input  logic              Tuse_rs,
  input  logic [1:0]        Tuse_rt,
  input  logic [1:0]        Tnew_D,
  input  logic [ADDR_W-1:0] WAddr_D,
  input  logic              RegWrite_D,
  output logic              stall,
  output logic [1:0]        fwd_rs_D,
  output logic [1:0]        fwd_rt_D,
  output logic [1:0]        fwd_rs_E,
  output logic [1:0]        fwd_rt_E,
  output logic              fwd_rt_M
);

  slot_t d_slot, e_q, m_q, w_d, w_q;
  logic [ADDR_W_DEF-1:0] rs_s, rt_s;
  logic rs_hz, rt_hz;

  assign rs_s = ADDR_W_DEF'(rs_D);
  assign rt_s = ADDR_W_DEF'(rt_D);

  // Unused source fields are zeroed so they can never trigger E-stage forwarding.
  always_comb begin
    d_slot      = '0;
    d_slot.we   = RegWrite_D;
    d_slot.addr = ADDR_W_DEF'(WAddr_D);
    d_slot.tnew = Tnew_D;
    d_slot.rs   = rs_use_D ? rs_s : '0;
    d_slot.rt   = rt_use_D ? rt_s : '0;
    w_d         = '0;
    w_d.we      = m_q.we;
    w_d.addr    = m_q.addr;
  end

  hazard_slot u_slot_e (.clk(clk), .reset(reset), .bubble(stall), .dec(1'b0), .d(d_slot), .q(e_q));
  hazard_slot u_slot_m (.clk(clk), .reset(reset), .bubble(1'b0),  .dec(1'b1), .d(e_q),    .q(m_q));
  hazard_slot u_slot_w (.clk(clk), .reset(reset), .bubble(1'b0),  .dec(1'b0), .d(w_d),    .q(w_q));

  function automatic logic [1:0] sel_d(input slot_t e, input slot_t m, input slot_t w,
                                       input logic [ADDR_W_DEF-1:0] s);
    if (slot_match(e, s) && (e.tnew == 2'd0)) return FWD_E;
    if (slot_match(m, s) && (m.tnew == 2'd0)) return FWD_M;
    if (slot_match(w, s)) return FWD_W;
    return FWD_RF;
  endfunction

  function automatic logic [1:0] sel_e(input slot_t m, input slot_t w,
                                       input logic [ADDR_W_DEF-1:0] s);
    if (slot_match(m, s) && (m.tnew == 2'd0)) return FWDE_M;
    if (slot_match(w, s)) return FWDE_W;
    return FWDE_PIPE;
  endfunction

  // M's stored tnew is already one stage closer, so it compares directly against Tuse.
  always_comb begin
    rs_hz = rs_use_D &&
            ((slot_match(e_q, rs_s) && (e_q.tnew > {1'b0, Tuse_rs})) ||
             (slot_match(m_q, rs_s) && (m_q.tnew > {1'b0, Tuse_rs})));
    rt_hz = rt_use_D &&
            ((slot_match(e_q, rt_s) && (e_q.tnew > Tuse_rt)) ||
             (slot_match(m_q, rt_s) && (m_q.tnew > Tuse_rt)));
    stall    = rs_hz | rt_hz;
    fwd_rs_D = sel_d(e_q, m_q, w_q, rs_s);
    fwd_rt_D = sel_d(e_q, m_q, w_q, rt_s);
    fwd_rs_E = sel_e(m_q, w_q, e_q.rs);
    fwd_rt_E = sel_e(m_q, w_q, e_q.rt);
    fwd_rt_M = slot_match(w_q, m_q.rt);
  end

  logic unused_fields;
  assign unused_fields = ^{m_q.rs, w_q.tnew, w_q.rs, w_q.rt};

endmodule
